// File: rtl/bidir_piso_tx.sv
// bidir_piso_tx: parallel-in, serial-out transmitter with bit order selectable per word.
// A word is loaded through a valid/ready handshake. It is then sent one bit per clock
// on sout, framed by sout_valid and sout_last.
// Optional feature macro: BIDIR_PISO_PARITY_EN appends an even-parity bit to each frame.
module bidir_piso_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef BIDIR_PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_q;
  logic             accept;
  logic             last_bit;
`ifdef BIDIR_PISO_PARITY_EN
  logic             par_q;
`endif

  // last_bit depends only on registers, so load_ready -> accept forms no combinational loop
  assign last_bit = (state == SHIFT) && (bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign accept   = load_valid && load_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: stay in SHIFT when a new word is taken in the last-bit cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are driven from registered state, so sout changes only on clock or reset
  always_comb begin
    load_ready = (state == IDLE) || last_bit;
    busy       = (state == SHIFT);
    sout_valid = (state == SHIFT);
    sout_last  = last_bit;
    sout       = 1'b0;
    if (state == SHIFT) begin
      sout = dir_q ? shreg[0] : shreg[WIDTH-1];
`ifdef BIDIR_PISO_PARITY_EN
      // The parity bit goes last for either bit order
      if (bit_cnt == CNT_W'(WIDTH)) sout = par_q;
`endif
    end
  end

  // Datapath: capture the word on accept, otherwise shift toward the emitting end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      dir_q   <= 1'b0;
`ifdef BIDIR_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      shreg   <= data_in;
      dir_q   <= dir;
      bit_cnt <= '0;
`ifdef BIDIR_PISO_PARITY_EN
      par_q   <= ^data_in;
`endif
    end else if (state == SHIFT) begin
      shreg   <= dir_q ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule
